// File: rtl/countdown16_pkg.sv
// Shared constants and state encoding for the countdown16 timer arbiter.
package countdown16_pkg;

    localparam int unsigned CD16_WIDTH = 16;
    localparam logic [CD16_WIDTH-1:0] CD16_RESET_COUNT = 16'hFFFF;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

endpackage

// File: rtl/countdown16_timer_arbiter_if.sv
// Request/grant/counter bundle between two requesters and the shared timer.
interface countdown16_timer_arbiter_if
    import countdown16_pkg::*;
#(
    parameter int WIDTH = CD16_WIDTH
);
    logic             req_a;
    logic [WIDTH-1:0] load_a;
    logic             req_b;
    logic [WIDTH-1:0] load_b;
    logic             abort;
    logic             grant_a;
    logic             grant_b;
    logic             busy;
    logic [WIDTH-1:0] count;
    logic             done_a;
    logic             done_b;

    // Requester side: drives requests, intervals and abort.
    modport master (
        output req_a, load_a, req_b, load_b, abort,
        input  grant_a, grant_b, busy, count, done_a, done_b
    );

    // Timer side: consumes requests, reports ownership and progress.
    modport slave (
        input  req_a, load_a, req_b, load_b, abort,
        output grant_a, grant_b, busy, count, done_a, done_b
    );
endinterface

// File: rtl/countdown16_load_core.sv
// Loadable down counter that saturates at zero; restore beats load beats decrement.
module countdown16_load_core #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_COUNT = '1
) (
    input  logic             clock0,
    input  logic             srst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             zero_o
);
    logic [WIDTH-1:0] count_q = RESET_COUNT;
    logic [WIDTH-1:0] count_d;

    // Next count: restore, load, or step down without wrapping below zero.
    always_comb begin
        // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        if (srst_i) begin
            count_d = RESET_COUNT;
        end else if (load_i) begin
            count_d = load_value_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Count register; restore to RESET_COUNT is carried in count_d.
    always_ff @(posedge clock0) begin
        // NOTE: non-blocking assignment for state so every flop samples pre-edge values.
        count_q <= count_d;
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/countdown16_timer_arbiter.sv
// Two-requester round-robin arbiter that lends one shared down-counter to the winner.
module countdown16_timer_arbiter
    import countdown16_pkg::*;
#(
    parameter int               WIDTH       = CD16_WIDTH,
    parameter logic [WIDTH-1:0] RESET_COUNT = CD16_RESET_COUNT
) (
    input  logic                        clock0,
    input  logic                        reset,
    countdown16_timer_arbiter_if.slave  bus
);
    state_e state_q   = IDLE;
    logic   grant_a_q = 1'b0;
    logic   grant_b_q = 1'b0;
    logic   done_a_q  = 1'b0;
    logic   done_b_q  = 1'b0;
    // 1 when B held the counter last, so A wins the next tie.
    logic   last_b_q  = 1'b1;

    logic             any_req;
    logic             start;
    logic             win_a;
    logic             owner_req;
    logic             cancel;
    logic             zero;
    logic             core_srst;
    logic             core_load;
    logic             core_en;
    logic [WIDTH-1:0] core_load_value;
    logic [WIDTH-1:0] core_count;

    assign any_req   = bus.req_a | bus.req_b;
    assign start     = (state_q == IDLE) && any_req && !bus.abort;
    assign win_a     = bus.req_a && (!bus.req_b || last_b_q);
    assign owner_req = grant_a_q ? bus.req_a : bus.req_b;
    assign cancel    = bus.abort || !owner_req;

    assign core_srst       = reset || ((state_q == COUNT) && (cancel || zero));
    assign core_load       = start;
    assign core_en         = (state_q == COUNT);
    assign core_load_value = win_a ? bus.load_a : bus.load_b;

    countdown16_load_core #(
        .WIDTH       (WIDTH),
        .RESET_COUNT (RESET_COUNT)
    ) u_core (
        .clock0       (clock0),
        .srst_i       (core_srst),
        .load_i       (core_load),
        .load_value_i (core_load_value),
        .en_i         (core_en),
        .count_o      (core_count),
        .zero_o       (zero)
    );

    // Ownership FSM: grant on a request, end on cancel (no done) or on zero (done pulse).
    always_ff @(posedge clock0) begin
        // NOTE: reset is synchronous, so it lives inside the clocked block, not the sensitivity list.
        if (reset) begin
            state_q   <= IDLE;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            last_b_q  <= 1'b1;
        end else begin
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= COUNT;
                        grant_a_q <= win_a;
                        grant_b_q <= !win_a;
                        last_b_q  <= !win_a;
                    end
                end
                COUNT: begin
                    // Cancel is checked first so it suppresses a same-edge completion.
                    if (cancel) begin
                        state_q   <= IDLE;
                        grant_a_q <= 1'b0;
                        grant_b_q <= 1'b0;
                    end else if (zero) begin
                        state_q   <= IDLE;
                        done_a_q  <= grant_a_q;
                        done_b_q  <= grant_b_q;
                        grant_a_q <= 1'b0;
                        grant_b_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    grant_a_q <= 1'b0;
                    grant_b_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant_a = grant_a_q;
    assign bus.grant_b = grant_b_q;
    assign bus.busy    = grant_a_q | grant_b_q;
    assign bus.count   = core_count;
    assign bus.done_a  = done_a_q;
    assign bus.done_b  = done_b_q;

endmodule
